// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared sizing and types for the eight-entry register bank and its read ports.
//   NUM_ENTRIES : number of storage entries
//   ADDR_W      : width of an entry address
//   entry_addr_t: entry address type used by every port
//   ZERO_IDX    : entry that reads as zero when the bank is built with ZERO_EN
package reg_bank_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int ADDR_W      = 3;

    typedef logic [ADDR_W-1:0] entry_addr_t;

    localparam entry_addr_t ZERO_IDX = 3'd7;

endpackage

// File: rtl/mux_2_1.sv
// mux_2_1
// Single-bit two-input multiplexer, the leaf cell of the read mux tree.
//   d0, d1 : data inputs
//   sel    : 0 selects d0, 1 selects d1
//   y      : selected bit
module mux_2_1 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_8_1.sv
// mux_8_1
// Single-bit eight-input multiplexer built as three levels of mux_2_1.
//   d   : eight data bits, d[i] is chosen when sel == i
//   sel : 3-bit select
//   y   : selected bit
module mux_8_1 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);

    logic [3:0] lvl1;
    logic [1:0] lvl2;

    // First level pairs neighbouring inputs on the select LSB.
    for (genvar i = 0; i < 4; i++) begin : g_lvl1
        mux_2_1 u_mux (
            .d0  (d[2*i]),
            .d1  (d[2*i+1]),
            .sel (sel[0]),
            .y   (lvl1[i])
        );
    end

    // Second level pairs the first-level results on the middle select bit.
    for (genvar i = 0; i < 2; i++) begin : g_lvl2
        mux_2_1 u_mux (
            .d0  (lvl1[2*i]),
            .d1  (lvl1[2*i+1]),
            .sel (sel[1]),
            .y   (lvl2[i])
        );
    end

    mux_2_1 u_lvl3 (
        .d0  (lvl2[0]),
        .d1  (lvl2[1]),
        .sel (sel[2]),
        .y   (y)
    );

endmodule

// File: rtl/reg_read_port.sv
// reg_read_port
// One combinational read port of the register bank. The entries are transposed
// into WIDTH eight-bit slices, each slice goes through its own mux_8_1, and the
// write-bypass and zero-entry overrides are applied after the mux.
//   entries  : all stored entries, entries[i] is entry i
//   busy     : scoreboard vector
//   rd_addr  : entry to read
//   wr_en, wr_addr, wr_data : live write port, used for forwarding
//   rsv_en, rsv_addr        : live reserve port, used for forwarded busy
//   rd_data  : read data
//   rd_busy  : selected entry has a pending producer
module reg_read_port
    import reg_bank_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_EN = 1'b1
) (
    input  logic [NUM_ENTRIES-1:0][WIDTH-1:0] entries,
    input  logic [NUM_ENTRIES-1:0]            busy,
    input  entry_addr_t                       rd_addr,
    input  logic                              wr_en,
    input  entry_addr_t                       wr_addr,
    input  logic [WIDTH-1:0]                  wr_data,
    input  logic                              rsv_en,
    input  entry_addr_t                       rsv_addr,
    output logic [WIDTH-1:0]                  rd_data,
    output logic                              rd_busy
);

    logic [WIDTH-1:0] mux_data;
    logic             is_zero;
    logic             bypass_hit;

    // Bit b of every entry forms one slice; one mux_8_1 per bit picks the entry.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NUM_ENTRIES-1:0] slice;

        for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
            assign slice[e] = entries[e][b];
        end

        mux_8_1 u_mux (
            .d   (slice),
            .sel (rd_addr),
            .y   (mux_data[b])
        );
    end

    // The zero entry always wins over forwarding; otherwise a same-cycle write
    // to the read entry is forwarded, and its busy reflects only a same-cycle
    // reservation of that entry since the write retires the old producer.
    always_comb begin
        is_zero    = ZERO_EN && (rd_addr == ZERO_IDX);
        bypass_hit = BYPASS && wr_en && (wr_addr == rd_addr) && !is_zero;
        rd_data    = mux_data;
        rd_busy    = busy[rd_addr];
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (bypass_hit) begin
            rd_data = wr_data;
            rd_busy = rsv_en && (rsv_addr == wr_addr);
        end
    end

endmodule

// File: rtl/reg_bank_8.sv
// reg_bank_8
// Eight-entry register bank with one write port, one reserve port, two
// combinational read ports and a per-entry busy scoreboard for hazard stalls.
//   clk, reset_n            : clock and asynchronous active-low reset
//   wr_en, wr_addr, wr_data : write port, clears busy of the written entry
//   rsv_en, rsv_addr        : reserve port, sets busy of the reserved entry
//   rd_addr_a, rd_addr_b    : read selects
//   rd_data_a, rd_data_b    : read data
//   rd_busy_a, rd_busy_b    : busy of the selected entries
//   busy                    : full scoreboard vector
module reg_bank_8
    import reg_bank_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  entry_addr_t            wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rsv_en,
    input  entry_addr_t            rsv_addr,
    input  entry_addr_t            rd_addr_a,
    input  entry_addr_t            rd_addr_b,
    output logic [WIDTH-1:0]       rd_data_a,
    output logic [WIDTH-1:0]       rd_data_b,
    output logic                   rd_busy_a,
    output logic                   rd_busy_b,
    output logic [NUM_ENTRIES-1:0] busy
);

    logic [NUM_ENTRIES-1:0][WIDTH-1:0] entries_q;
    logic [NUM_ENTRIES-1:0]            busy_q;
    logic [NUM_ENTRIES-1:0]            wr_hit;
    logic [NUM_ENTRIES-1:0]            rsv_hit;
    logic                              wr_live;
    logic                              rsv_live;

    // Strobes are gated by reset so nothing is forwarded while the bank is
    // held in reset and every read output stays at zero.
    assign wr_live  = wr_en && reset_n;
    assign rsv_live = rsv_en && reset_n;

    // One-hot write and reserve decode; the zero entry never decodes so it
    // can neither store data nor become busy.
    always_comb begin
        wr_hit  = '0;
        rsv_hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            wr_hit[i]  = wr_live && (wr_addr == entry_addr_t'(i));
            rsv_hit[i] = rsv_live && (rsv_addr == entry_addr_t'(i));
            if (ZERO_EN && (entry_addr_t'(i) == ZERO_IDX)) begin
                wr_hit[i]  = 1'b0;
                rsv_hit[i] = 1'b0;
            end
        end
    end

    // Storage and scoreboard. A reserve outranks a write to the same entry
    // because it announces a newer producer than the one just retiring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_q <= '0;
            busy_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wr_hit[i]) begin
                    entries_q[i] <= wr_data;
                end
                if (rsv_hit[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_hit[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = busy_q;

    reg_read_port #(
        .WIDTH   (WIDTH),
        .BYPASS  (BYPASS),
        .ZERO_EN (ZERO_EN)
    ) u_port_a (
        .entries  (entries_q),
        .busy     (busy_q),
        .rd_addr  (rd_addr_a),
        .wr_en    (wr_live),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_live),
        .rsv_addr (rsv_addr),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a)
    );

    reg_read_port #(
        .WIDTH   (WIDTH),
        .BYPASS  (BYPASS),
        .ZERO_EN (ZERO_EN)
    ) u_port_b (
        .entries  (entries_q),
        .busy     (busy_q),
        .rd_addr  (rd_addr_b),
        .wr_en    (wr_live),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_live),
        .rsv_addr (rsv_addr),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b)
    );

endmodule

// File: tb/tb_reg_bank_8.sv
// tb_reg_bank_8
// Self-checking bench for reg_bank_8. Two instances share all inputs: one with
// forwarding enabled and one without. A behavioural model of the bank produces
// the expected value of every output; expectations are queued when a step is
// driven and popped and compared once the combinational outputs have settled.
module tb_reg_bank_8;
    import reg_bank_pkg::*;

    localparam int W = 64;

    logic              clk;
    logic              reset_n;
    logic              wr_en;
    entry_addr_t       wr_addr;
    logic [W-1:0]      wr_data;
    logic              rsv_en;
    entry_addr_t       rsv_addr;
    entry_addr_t       rd_addr_a;
    entry_addr_t       rd_addr_b;

    logic [W-1:0]      rd_data_a, rd_data_b;
    logic              rd_busy_a, rd_busy_b;
    logic [7:0]        busy;

    logic [W-1:0]      nb_rd_data_a, nb_rd_data_b;
    logic              nb_rd_busy_a, nb_rd_busy_b;
    logic [7:0]        nb_busy;

    typedef struct {
        int           kind;
        logic [W-1:0] exp;
    } exp_t;

    exp_t         sb[$];
    string        curTag;
    logic [W-1:0] mem [8];
    logic [7:0]   bsy;
    int           passCount;
    int           checkCount;

    reg_bank_8 #(.WIDTH(W), .BYPASS(1'b1), .ZERO_EN(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_busy_a (rd_busy_a),
        .rd_busy_b (rd_busy_b),
        .busy      (busy)
    );

    reg_bank_8 #(.WIDTH(W), .BYPASS(1'b0), .ZERO_EN(1'b1)) dut_nb (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (nb_rd_data_a),
        .rd_data_b (nb_rd_data_b),
        .rd_busy_a (nb_rd_busy_a),
        .rd_busy_b (nb_rd_busy_b),
        .busy      (nb_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read data from the model for a given address and bypass mode.
    function automatic logic [W-1:0] expRd(entry_addr_t addr, bit byp);
        if (!reset_n) return '0;
        if (addr == 3'd7) return '0;
        if (byp && wr_en && (wr_addr == addr)) return wr_data;
        return mem[addr];
    endfunction

    // Expected read busy from the model for a given address and bypass mode.
    function automatic logic expBusy(entry_addr_t addr, bit byp);
        if (!reset_n) return 1'b0;
        if (addr == 3'd7) return 1'b0;
        if (byp && wr_en && (wr_addr == addr)) return rsv_en && (rsv_addr == wr_addr);
        return bsy[addr];
    endfunction

    // Observed value of output number kind, zero-extended to W bits.
    function automatic logic [W-1:0] observe(int kind);
        case (kind)
            0:       return rd_data_a;
            1:       return rd_data_b;
            2:       return {{(W-1){1'b0}}, rd_busy_a};
            3:       return {{(W-1){1'b0}}, rd_busy_b};
            4:       return {{(W-8){1'b0}}, busy};
            5:       return nb_rd_data_a;
            6:       return nb_rd_data_b;
            7:       return {{(W-1){1'b0}}, nb_rd_busy_a};
            8:       return {{(W-1){1'b0}}, nb_rd_busy_b};
            default: return {{(W-8){1'b0}}, nb_busy};
        endcase
    endfunction

    // Queue the model's expectation for every output of both instances.
    task automatic pushAll();
        exp_t e;
        for (int k = 0; k < 10; k++) begin
            e.kind = k;
            case (k)
                0:       e.exp = expRd(rd_addr_a, 1'b1);
                1:       e.exp = expRd(rd_addr_b, 1'b1);
                2:       e.exp = {{(W-1){1'b0}}, expBusy(rd_addr_a, 1'b1)};
                3:       e.exp = {{(W-1){1'b0}}, expBusy(rd_addr_b, 1'b1)};
                5:       e.exp = expRd(rd_addr_a, 1'b0);
                6:       e.exp = expRd(rd_addr_b, 1'b0);
                7:       e.exp = {{(W-1){1'b0}}, expBusy(rd_addr_a, 1'b0)};
                8:       e.exp = {{(W-1){1'b0}}, expBusy(rd_addr_b, 1'b0)};
                default: e.exp = {{(W-8){1'b0}}, bsy};
            endcase
            sb.push_back(e);
        end
    endtask

    // Drive one step's inputs just after a falling edge and queue expectations.
    task automatic applyStimulus(input string tag, input logic wen, input entry_addr_t wa,
                                 input logic [W-1:0] wd, input logic ren, input entry_addr_t ra,
                                 input entry_addr_t rda, input entry_addr_t rdb);
        @(negedge clk);
        wr_en     = wen;
        wr_addr   = wa;
        wr_data   = wd;
        rsv_en    = ren;
        rsv_addr  = ra;
        rd_addr_a = rda;
        rd_addr_b = rdb;
        #1;
        curTag = tag;
        pushAll();
    endtask

    // Pop every queued expectation and compare it with the settled outputs.
    task automatic checkOutput();
        exp_t         e;
        logic [W-1:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            checkCount++;
            assert (obs === e.exp) passCount++;
            else $error("[TB] FAIL %s out%0d observed=%h expected=%h", curTag, e.kind, obs, e.exp);
        end
    endtask

    // Advance the model across the next rising edge.
    task automatic clockEdge();
        @(posedge clk);
        if (reset_n) begin
            if (wr_en && (wr_addr != 3'd7)) begin
                mem[wr_addr] = wr_data;
                bsy[wr_addr] = 1'b0;
            end
            if (rsv_en && (rsv_addr != 3'd7)) begin
                bsy[rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic runStep(input string tag, input logic wen, input entry_addr_t wa,
                           input logic [W-1:0] wd, input logic ren, input entry_addr_t ra,
                           input entry_addr_t rda, input entry_addr_t rdb);
        applyStimulus(tag, wen, wa, wd, ren, ra, rda, rdb);
        checkOutput();
        clockEdge();
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        bsy        = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Held in reset with an active write to entry 2 being read.
        reset_n   = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 3'd2;
        wr_data   = 64'hAA;
        rsv_en    = 1'b0;
        rsv_addr  = 3'd0;
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd2;
        #1;
        curTag = "reset_hold";
        pushAll();
        checkOutput();
        clockEdge();
        #1;
        curTag = "reset_after_edge";
        pushAll();
        checkOutput();

        @(negedge clk);
        reset_n = 1'b1;
        wr_en   = 1'b0;

        runStep("post_reset_idle", 0, 3'd0, 64'h0,    0, 3'd0, 3'd2, 3'd0);
        runStep("wr3",             1, 3'd3, 64'h1234, 0, 3'd0, 3'd3, 3'd5);
        runStep("wr5",             1, 3'd5, 64'hFFFF, 0, 3'd0, 3'd3, 3'd5);
        runStep("rd3_rd5",         0, 3'd0, 64'h0,    0, 3'd0, 3'd3, 3'd5);
        runStep("wr4_11",          1, 3'd4, 64'h11,   0, 3'd0, 3'd4, 3'd4);
        runStep("bypass_wr4_22",   1, 3'd4, 64'h22,   0, 3'd0, 3'd4, 3'd3);
        runStep("rd4_after",       0, 3'd0, 64'h0,    0, 3'd0, 3'd4, 3'd4);
        runStep("rsv1",            0, 3'd0, 64'h0,    1, 3'd1, 3'd1, 3'd1);
        runStep("busy1_set",       0, 3'd0, 64'h0,    0, 3'd0, 3'd1, 3'd0);
        runStep("wr1_clears",      1, 3'd1, 64'h55,   0, 3'd0, 3'd1, 3'd1);
        runStep("busy1_clear",     0, 3'd0, 64'h0,    0, 3'd0, 3'd1, 3'd1);
        runStep("wr_rsv1_same",    1, 3'd1, 64'h66,   1, 3'd1, 3'd1, 3'd0);
        runStep("rsv_wins",        0, 3'd0, 64'h0,    0, 3'd0, 3'd1, 3'd1);
        runStep("wr1_rsv2",        1, 3'd1, 64'h77,   1, 3'd2, 3'd1, 3'd2);
        runStep("independent",     0, 3'd0, 64'h0,    0, 3'd0, 3'd1, 3'd2);
        runStep("zero_wr_rsv",     1, 3'd7, 64'hDEAD, 1, 3'd7, 3'd7, 3'd7);
        runStep("zero_after",      0, 3'd0, 64'h0,    0, 3'd0, 3'd7, 3'd7);
        runStep("wr_non_busy",     1, 3'd6, 64'h0123_4567_89AB_CDEF, 0, 3'd0, 3'd6, 3'd6);
        runStep("same_entry_ab",   0, 3'd0, 64'h0,    0, 3'd0, 3'd6, 3'd6);

        // A short burst of random traffic against the model.
        for (int i = 0; i < 12; i++) begin
            runStep("random",
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // Fill two entries, then drop reset between edges with traffic pending.
        runStep("fill3", 1, 3'd3, 64'hCAFE, 1, 3'd2, 3'd3, 3'd2);
        applyStimulus("pre_async_rst", 1, 3'd3, 64'hABCD, 1, 3'd5, 3'd3, 3'd2);
        checkOutput();
        #1;
        reset_n = 1'b0;
        #1;
        bsy = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        curTag = "async_rst";
        pushAll();
        checkOutput();
        clockEdge();
        @(negedge clk);
        reset_n = 1'b1;
        wr_en   = 1'b0;
        rsv_en  = 1'b0;

        runStep("post_async_rst", 0, 3'd0, 64'h0, 0, 3'd0, 3'd3, 3'd5);
        runStep("resume_wr2",     1, 3'd2, 64'h5A5A, 0, 3'd0, 3'd2, 3'd3);
        runStep("resume_rd2",     0, 3'd0, 64'h0,    0, 3'd0, 3'd2, 3'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
